// File: rtl/ov7670_init_sequencer.sv
// OV7670 boot-time register programming sequencer.
// Waits out the power-up settle time after a start edge, then walks a
// {reg_addr,reg_data} table held in an external two-stage synchronous ROM,
// issuing one SCCB write per entry over a req/ack handshake.
// Entries 16'hFFnn are markers: FFFF ends the table, FF00 is skipped and
// FF01..FFFE insert a delay of nn*DELAY_UNIT cycles.
//
// state      | meaning
// IDLE       | waiting for a start edge after reset
// POWERUP    | settle delay before the first fetch
// FETCH      | rom_addr presented to the ROM
// FETCH_WAIT | second ROM pipeline cycle
// DECODE     | rom_data valid, classify entry
// DELAY      | in-table delay marker countdown
// WRITE_REQ  | wr_addr/wr_data latched, raise wr_req
// WRITE_WAIT | wr_req high, waiting for wr_ack or timeout
// GAP        | idle spacing after an acked write
// NEXT       | advance to the next entry or finish at the last one
// DONE       | table completed
// ERROR      | a write timed out

module ov7670_init_sequencer #(
   parameter int unsigned ROM_AW         = 8,
   parameter int unsigned POWERUP_CYCLES = 1_500_000,
   parameter int unsigned GAP_CYCLES     = 50,
   parameter int unsigned DELAY_UNIT     = 50_000,
   parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
   input  logic              clk50,
   input  logic              resetn,
   input  logic              start,
   output logic [ROM_AW-1:0] rom_addr,
   input  logic [15:0]       rom_data,
   output logic              wr_req,
   output logic [7:0]        wr_addr,
   output logic [7:0]        wr_data,
   input  logic              wr_ack,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ROM_AW:0]   write_count
);

   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   // One shared down-counter serves power-up, delay markers, write timeout and gap.
   localparam int unsigned MAX_CYC = max4(POWERUP_CYCLES, 254 * DELAY_UNIT,
                                          TIMEOUT_CYCLES, GAP_CYCLES);
   localparam int TW = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

   localparam logic [TW-1:0]     T_ONE    = TW'(1);
   localparam logic [TW-1:0]     PU_LOAD  = TW'(POWERUP_CYCLES - 1);
   localparam logic [TW-1:0]     TO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0]     GAP_LOAD = TW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0]     DU_T     = TW'(DELAY_UNIT);
   localparam logic [ROM_AW-1:0] A_ONE    = ROM_AW'(1);
   localparam logic [ROM_AW:0]   C_ONE    = (ROM_AW + 1)'(1);

   typedef enum logic [3:0] {
      IDLE, POWERUP, FETCH, FETCH_WAIT, DECODE, DELAY,
      WRITE_REQ, WRITE_WAIT, GAP, NEXT, DONE, ERROR
   } state_t;

   state_t          state, state_nxt;
   logic [TW-1:0]   timer;
   logic [TW-1:0]   delay_load;
   logic            start_q;
   logic            start_edge;
   logic            launch;
   logic            timer_zero;
   logic            is_marker, is_end, is_skip;
   logic            last_addr;

   assign start_edge = start & ~start_q;
   assign launch     = start_edge & ((state == IDLE) | (state == DONE) | (state == ERROR));
   assign timer_zero = (timer == '0);
   assign is_marker  = (rom_data[15:8] == 8'hFF);
   assign is_end     = (rom_data == 16'hFFFF);
   assign is_skip    = (rom_data == 16'hFF00);
   assign last_addr  = (rom_addr == '1);
   assign delay_load = TW'(rom_data[7:0]) * DU_T - T_ONE;

   // State register
   always_ff @(posedge clk50) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERROR: if (launch) state_nxt = POWERUP;
         POWERUP:           if (timer_zero) state_nxt = FETCH;
         FETCH:             state_nxt = FETCH_WAIT;
         FETCH_WAIT:        state_nxt = DECODE;
         DECODE: begin
            if (is_end)         state_nxt = DONE;
            else if (is_skip)   state_nxt = NEXT;
            else if (is_marker) state_nxt = DELAY;
            else                state_nxt = WRITE_REQ;
         end
         DELAY:             if (timer_zero) state_nxt = NEXT;
         WRITE_REQ:         state_nxt = WRITE_WAIT;
         WRITE_WAIT: begin
            // an ack arriving on the expiry cycle still wins
            if (wr_ack)          state_nxt = GAP;
            else if (timer_zero) state_nxt = ERROR;
         end
         GAP:               if (timer_zero) state_nxt = NEXT;
         NEXT:              state_nxt = last_addr ? DONE : FETCH;
         default:           state_nxt = IDLE;
      endcase
   end

   // Status outputs decoded from state
   always_comb begin
      wr_req = (state == WRITE_WAIT);
      done   = (state == DONE);
      err    = (state == ERROR);
      busy   = !((state == IDLE) || (state == DONE) || (state == ERROR));
   end

   // Shared down-counter: loaded on entry to each timed state, stops at zero
   always_ff @(posedge clk50) begin
      if (!resetn) begin
         timer <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERROR:   if (launch) timer <= PU_LOAD;
            POWERUP, DELAY, GAP: if (!timer_zero) timer <= timer - T_ONE;
            DECODE:              timer <= delay_load;
            WRITE_REQ:           timer <= TO_LOAD;
            WRITE_WAIT: begin
               if (wr_ack)           timer <= GAP_LOAD;
               else if (!timer_zero) timer <= timer - T_ONE;
            end
            default: ;
         endcase
      end
   end

   // Table pointer, write counter, latched write payload and start-edge history
   always_ff @(posedge clk50) begin
      if (!resetn) begin
         start_q     <= 1'b0;
         rom_addr    <= '0;
         write_count <= '0;
         wr_addr     <= '0;
         wr_data     <= '0;
      end else begin
         start_q <= start;
         if (launch) begin
            rom_addr    <= '0;
            write_count <= '0;
         end
         if ((state == NEXT) && !last_addr) rom_addr <= rom_addr + A_ONE;
         if ((state == WRITE_WAIT) && wr_ack) write_count <= write_count + C_ONE;
         if ((state == DECODE) && !is_marker) begin
            wr_addr <= rom_data[15:8];
            wr_data <= rom_data[7:0];
         end
      end
   end

endmodule

// File: tb/tb_ov7670_init_sequencer.sv
// Bench for ov7670_init_sequencer: table walks against a cycle-level reference
// model, timeout, reset abort, spurious ack/start, and end-of-table without wrap.
module tb_ov7670_init_sequencer;
   localparam int P   = 10;
   localparam int G   = 4;
   localparam int U   = 5;
   localparam int TO  = 100;
   localparam int AW  = 4;
   localparam int AW2 = 2;

   logic clk50 = 1'b0;
   logic resetn = 1'b0;

   logic            start = 1'b0;
   logic [AW-1:0]   rom_addr;
   logic [15:0]     rom_data = 16'h0;
   logic            wr_req;
   logic [7:0]      wr_addr, wr_data;
   logic            wr_ack;
   logic            busy, done, err;
   logic [AW:0]     write_count;

   logic            start2 = 1'b0;
   logic [AW2-1:0]  rom_addr2;
   logic [15:0]     rom_data2 = 16'h0;
   logic            wr_req2;
   logic [7:0]      wr_addr2, wr_data2;
   logic            ack2 = 1'b0;
   logic            busy2, done2, err2;
   logic [AW2:0]    write_count2;

   ov7670_init_sequencer #(.ROM_AW(AW), .POWERUP_CYCLES(P), .GAP_CYCLES(G),
                           .DELAY_UNIT(U), .TIMEOUT_CYCLES(TO)) u_dut (
      .clk50(clk50), .resetn(resetn), .start(start), .rom_addr(rom_addr),
      .rom_data(rom_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ack(wr_ack), .busy(busy), .done(done), .err(err), .write_count(write_count));

   ov7670_init_sequencer #(.ROM_AW(AW2), .POWERUP_CYCLES(P), .GAP_CYCLES(G),
                           .DELAY_UNIT(U), .TIMEOUT_CYCLES(TO)) u_dut2 (
      .clk50(clk50), .resetn(resetn), .start(start2), .rom_addr(rom_addr2),
      .rom_data(rom_data2), .wr_req(wr_req2), .wr_addr(wr_addr2), .wr_data(wr_data2),
      .wr_ack(ack2), .busy(busy2), .done(done2), .err(err2), .write_count(write_count2));

   always #5 clk50 = ~clk50;

   int cyc = 0;
   always @(posedge clk50) cyc <= cyc + 1;

   // Two-stage synchronous ROMs
   logic [15:0] rom1 [16];
   logic [15:0] rom2 [4];
   logic [15:0] rom1_q = 16'h0, rom2_q = 16'h0;
   always @(posedge clk50) begin
      rom1_q    <= rom1[rom_addr];
      rom_data  <= rom1_q;
      rom2_q    <= rom2[rom_addr2];
      rom_data2 <= rom2_q;
   end

   int total = 0;
   int bad = 0;

   // Observation of DUT1
   int          rise_cyc[$];
   logic [7:0]  got_a[$], got_d[$];
   int          fall_cyc = -1, done_cyc = -1, err_cyc = -1, stab_bad = 0;
   logic        req_prev = 0, done_prev = 0, err_prev = 0;
   logic [7:0]  last_a = 0, last_d = 0;

   // Ack stimulus for DUT1
   bit   ack_en = 0, noise_en = 0;
   int   ack_k = 1, ack_at = -1;
   logic auto_ack = 0, noise_ack = 0, man_ack = 0;
   assign wr_ack = auto_ack | noise_ack | man_ack;

   initial forever begin
      @(posedge clk50);
      #1;
      if (wr_req && !req_prev) begin
         rise_cyc.push_back(cyc);
         got_a.push_back(wr_addr);
         got_d.push_back(wr_data);
         ack_at = ack_en ? cyc + ack_k : -1;
      end
      if (wr_req && req_prev && ((wr_addr !== last_a) || (wr_data !== last_d))) stab_bad++;
      if (!wr_req && req_prev) fall_cyc = cyc;
      if (done && !done_prev) done_cyc = cyc;
      if (err && !err_prev) err_cyc = cyc;
      req_prev = wr_req; done_prev = done; err_prev = err;
      last_a = wr_addr; last_d = wr_data;
   end

   initial forever begin
      @(negedge clk50);
      auto_ack  = (ack_at >= 0) && (cyc + 1 == ack_at);
      noise_ack = noise_en && !wr_req && ($urandom_range(0, 1) == 1);
   end

   // Reference model: expected writes, end cycle and final status from table rules
   int         exp_rise[$];
   logic [7:0] exp_a[$], exp_d[$];
   int         exp_end, exp_cnt, exp_addr;
   bit         exp_done;

   task automatic model_run(input int s, input int k);
      int f, a, nxt;
      logic [15:0] e;
      bit fin;
      exp_rise.delete(); exp_a.delete(); exp_d.delete();
      f = s + P; a = 0; nxt = 0; exp_cnt = 0; fin = 0; exp_done = 0; exp_end = 0;
      while (!fin) begin
         e = rom1[a];
         if (e == 16'hFFFF) begin
            exp_end = f + 3; exp_done = 1; fin = 1;
         end else begin
            if (e[15:8] == 8'hFF) begin
               nxt = f + 4 + int'(e[7:0]) * U;
            end else begin
               exp_rise.push_back(f + 4);
               exp_a.push_back(e[15:8]);
               exp_d.push_back(e[7:0]);
               if (k <= 0 || k > TO) begin
                  exp_end = f + 4 + TO; exp_done = 0; fin = 1;
               end else begin
                  exp_cnt++;
                  nxt = f + 4 + k + G + 1;
               end
            end
            if (!fin) begin
               if (a == (1 << AW) - 1) begin
                  exp_end = nxt; exp_done = 1; fin = 1;
               end else begin
                  a++; f = nxt;
               end
            end
         end
      end
      exp_addr = a;
   endtask

   task automatic run_check(input int k, input string nm);
      int s, n, m;
      rise_cyc.delete(); got_a.delete(); got_d.delete();
      stab_bad = 0; done_cyc = -1; err_cyc = -1; fall_cyc = -1;
      ack_en = (k > 0); ack_k = k; ack_at = -1;
      @(negedge clk50) start = 0;
      @(negedge clk50) start = 1;
      @(posedge clk50);
      #1 s = cyc;
      total++;
      if ({busy, done, err} !== 3'b100) begin
         bad++; $display("FAIL %s launch: busy/done/err=%b want 100", nm, {busy, done, err});
      end
      model_run(s, k);
      n = 0;
      while (!(done || err) && n < 5000) begin @(posedge clk50); #1; n++; end
      repeat (2) @(negedge clk50);
      total++;
      if (n >= 5000) begin bad++; $display("FAIL %s finish: no done/err within 5000 cycles", nm); end
      total++;
      if (rise_cyc.size() != exp_rise.size()) begin
         bad++; $display("FAIL %s nwrites: got %0d want %0d", nm, rise_cyc.size(), exp_rise.size());
      end
      m = (rise_cyc.size() < exp_rise.size()) ? rise_cyc.size() : exp_rise.size();
      for (int i = 0; i < m; i++) begin
         total++;
         if (rise_cyc[i] !== exp_rise[i] || got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
            bad++;
            $display("FAIL %s write%0d: got %02h/%02h at %0d want %02h/%02h at %0d", nm, i,
                     got_a[i], got_d[i], rise_cyc[i] - s, exp_a[i], exp_d[i], exp_rise[i] - s);
         end
      end
      total++;
      if ((exp_done ? done_cyc : err_cyc) !== exp_end) begin
         bad++; $display("FAIL %s end_cycle: got %0d want %0d", nm,
                         (exp_done ? done_cyc : err_cyc) - s, exp_end - s);
      end
      total++;
      if ({busy, done, err} !== {1'b0, exp_done, !exp_done}) begin
         bad++; $display("FAIL %s status: busy/done/err=%b want %b", nm, {busy, done, err},
                         {1'b0, exp_done, !exp_done});
      end
      total++;
      if (int'(write_count) !== exp_cnt) begin
         bad++; $display("FAIL %s write_count: got %0d want %0d", nm, write_count, exp_cnt);
      end
      total++;
      if (int'(rom_addr) !== exp_addr) begin
         bad++; $display("FAIL %s rom_addr: got %0d want %0d", nm, rom_addr, exp_addr);
      end
      total++;
      if (stab_bad != 0) begin
         bad++; $display("FAIL %s payload_stable: %0d changes while wr_req want 0", nm, stab_bad);
      end
   endtask

   task automatic fill_rom(input logic [15:0] t0, input logic [15:0] t1,
                           input logic [15:0] t2, input logic [15:0] t3);
      for (int i = 0; i < 16; i++) rom1[i] = 16'h0101;
      rom1[0] = t0; rom1[1] = t1; rom1[2] = t2; rom1[3] = t3;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 16; i++) rom1[i] = 16'hFFFF;
      for (int i = 0; i < 4; i++) rom2[i] = 16'hFFFF;
      resetn = 0;
      repeat (3) @(posedge clk50);
      #1;
      total++;
      if ({wr_req, busy, done, err} !== 4'b0 || rom_addr !== '0 || write_count !== '0 ||
          wr_addr !== 8'h0 || wr_data !== 8'h0) begin
         bad++; $display("FAIL reset_outputs: req/busy/done/err=%b addr=%0d cnt=%0d wr=%02h/%02h want all 0",
                         {wr_req, busy, done, err}, rom_addr, write_count, wr_addr, wr_data);
      end
      @(negedge clk50) resetn = 1;
      repeat (5) @(negedge clk50);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%b want 0", busy); end
   endtask

   task automatic test_table;
      fill_rom(16'h1280, 16'hFF02, 16'h1100, 16'hFFFF);
      run_check(20, "table");
   endtask

   task automatic test_empty;
      fill_rom(16'hFFFF, 16'h1234, 16'h5678, 16'hFFFF);
      run_check(10, "empty");
   endtask

   task automatic test_timeout;
      fill_rom(16'h3A04, 16'hFFFF, 16'h0000, 16'h0000);
      run_check(0, "timeout");
      total++;
      if (exp_rise.size() != 1 || fall_cyc !== exp_rise[0] + TO) begin
         bad++; $display("FAIL timeout_fall: wr_req fell at %0d want %0d", fall_cyc,
                         (exp_rise.size() > 0) ? exp_rise[0] + TO : -1);
      end
      run_check(15, "timeout_restart");
   endtask

   task automatic test_ack_boundary;
      fill_rom(16'h4455, 16'hFF00, 16'h6677, 16'hFFFF);
      run_check(1, "ack_first_cycle");
      run_check(TO, "ack_at_expiry");
   endtask

   task automatic test_random;
      int r;
      for (int it = 0; it < 6; it++) begin
         for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      rom1[i] = 16'hFF00;
            else if (r == 1) rom1[i] = {8'hFF, 8'($urandom_range(1, 6))};
            else if (r == 2 && it[0]) rom1[i] = 16'hFFFF;
            else             rom1[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
         end
         noise_en = ($urandom_range(0, 1) == 1);
         run_check($urandom_range(1, TO), $sformatf("random%0d", it));
      end
      noise_en = 0;
   endtask

   task automatic test_spurious;
      int cnt0;
      int nr0;
      fill_rom(16'h5510, 16'hFF01, 16'h6620, 16'hFFFF);
      noise_en = 1;
      fork
         run_check(30, "spurious");
         begin
            repeat (P + 8) @(negedge clk50);
            start = 0;
            @(negedge clk50) start = 1;
         end
      join
      cnt0 = int'(write_count);
      nr0 = rise_cyc.size();
      repeat (40) @(negedge clk50);
      total++;
      if ({busy, done} !== 2'b01 || int'(write_count) !== cnt0 || rise_cyc.size() != nr0) begin
         bad++; $display("FAIL spurious_hold: busy/done=%b cnt=%0d rises=%0d want 01 cnt=%0d rises=%0d",
                         {busy, done}, write_count, rise_cyc.size(), cnt0, nr0);
      end
      noise_en = 0;
   endtask

   task automatic test_reset_abort;
      int n;
      fill_rom(16'h1234, 16'hFFFF, 16'h0000, 16'h0000);
      ack_en = 0; ack_at = -1;
      @(negedge clk50) start = 0;
      @(negedge clk50) start = 1;
      @(negedge clk50) start = 0;
      n = 0;
      while (!wr_req && n < 200) begin @(posedge clk50); #1; n++; end
      total++;
      if (n >= 200) begin bad++; $display("FAIL abort_req: wr_req not seen within 200 cycles"); end
      repeat ($urandom_range(1, 20)) @(negedge clk50);
      resetn = 0;
      @(posedge clk50);
      #1;
      total++;
      if ({wr_req, busy, done, err} !== 4'b0 || rom_addr !== '0 || write_count !== '0 ||
          wr_addr !== 8'h0 || wr_data !== 8'h0) begin
         bad++; $display("FAIL abort_outputs: req/busy/done/err=%b addr=%0d cnt=%0d wr=%02h/%02h want all 0",
                         {wr_req, busy, done, err}, rom_addr, write_count, wr_addr, wr_data);
      end
      @(negedge clk50) resetn = 1;
      rise_cyc.delete(); got_a.delete(); got_d.delete();
      repeat (3) begin
         @(negedge clk50) man_ack = 1;
         @(negedge clk50) man_ack = 0;
      end
      repeat (30) @(negedge clk50);
      total++;
      if (rise_cyc.size() != 0 || busy !== 1'b0 || write_count !== '0 || wr_req !== 1'b0) begin
         bad++; $display("FAIL abort_stays_idle: rises=%0d busy=%b cnt=%0d req=%b want 0 0 0 0",
                         rise_cyc.size(), busy, write_count, wr_req);
      end
   endtask

   task automatic test_no_wrap;
      int n;
      for (int i = 0; i < 4; i++) rom2[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
      @(negedge clk50) start2 = 0;
      @(negedge clk50) start2 = 1;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!wr_req2 && n < 500) begin @(posedge clk50); #1; n++; end
         total++;
         if (n >= 500 || {wr_addr2, wr_data2} !== rom2[i]) begin
            bad++; $display("FAIL nowrap_write%0d: got %02h%02h (wait %0d) want %04h", i,
                            wr_addr2, wr_data2, n, rom2[i]);
         end
         repeat ($urandom_range(1, 30)) @(negedge clk50);
         ack2 = 1;
         @(negedge clk50) ack2 = 0;
      end
      n = 0;
      while (!done2 && n < 500) begin @(posedge clk50); #1; n++; end
      total++;
      if (done2 !== 1'b1 || busy2 !== 1'b0 || int'(write_count2) !== 4 || int'(rom_addr2) !== 3) begin
         bad++; $display("FAIL nowrap_end: done=%b busy=%b cnt=%0d addr=%0d want 1 0 4 3",
                         done2, busy2, write_count2, rom_addr2);
      end
      repeat (20) @(negedge clk50);
      total++;
      if (wr_req2 !== 1'b0 || int'(write_count2) !== 4 || done2 !== 1'b1 || err2 !== 1'b0) begin
         bad++; $display("FAIL nowrap_hold: req=%b cnt=%0d done=%b err=%b want 0 4 1 0",
                         wr_req2, write_count2, done2, err2);
      end
   endtask

   initial begin
      test_reset;
      test_table;
      test_empty;
      test_timeout;
      test_ack_boundary;
      test_random;
      test_spurious;
      test_reset_abort;
      test_no_wrap;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
